// File: rtl/vsim_send_arb_if.sv
// Requester-side and send-port-side signals of the message-granular send arbiter.
interface vsim_send_arb_if #(
  parameter int width = 32,
  parameter int NREQ  = 4
);
  localparam int SW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*width-1:0] req_v;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  beat_valid;
  logic                  beat_ready;
  logic [width-1:0]      beat_v;
  logic                  beat_last;
  logic [SW-1:0]         beat_src;
  logic [15:0]           msg_count;

  modport master (
    output req_valid, req_v, req_last, beat_ready,
    input  req_ready, beat_valid, beat_v, beat_last, beat_src, msg_count
  );

  modport slave (
    input  req_valid, req_v, req_last, beat_ready,
    output req_ready, beat_valid, beat_v, beat_last, beat_src, msg_count
  );
endinterface

// File: rtl/vsim_send_arb.sv
// Round-robin arbiter merging NREQ beat streams onto one send port, locking
// the output to a requester for the duration of its message.
module vsim_send_arb_lane (
  input  logic sel,
  input  logic can_load,
  input  logic rst,
  output logic ready
);
  assign ready = sel & can_load & ~rst;
endmodule

module vsim_send_arb #(
  parameter int width = 32,
  parameter int NREQ  = 4
) (
  input logic            CLK,
  input logic            nRST,
  vsim_send_arb_if.slave bus
);
  localparam int SW = $clog2(NREQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                      state, state_nx;
  logic [SW-1:0]               grant, grant_nx, rr_ptr, rr_nx, win, sel;
  logic                        win_found, sel_act, can_load, xfer;
  logic [NREQ-1:0]             sel_oh, ready;
  logic [NREQ-1:0][width-1:0]  req_data;

  logic                        out_valid, out_last;
  logic [width-1:0]            out_v;
  logic [SW-1:0]               out_src;
  logic [15:0]                 msg_cnt;

  assign req_data = bus.req_v;
  assign can_load = ~out_valid | bus.beat_ready;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win       = rr_ptr;
    win_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && bus.req_valid[idx]) begin
        win       = SW'(idx);
        win_found = 1'b1;
      end
    end
  end

  // While locked the grantee owns ready even if it has stalled its valid.
  assign sel     = (state == LOCKED) ? grant : win;
  assign sel_act = (state == LOCKED) | win_found;
  assign xfer    = sel_act & bus.req_valid[sel] & can_load & ~nRST;

  always_comb begin
    sel_oh = '0;
    if (sel_act) sel_oh[sel] = 1'b1;
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    vsim_send_arb_lane u_lane (
      .sel      (sel_oh[i]),
      .can_load (can_load),
      .rst      (nRST),
      .ready    (ready[i])
    );
  end
  assign bus.req_ready = ready;

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    rr_nx    = rr_ptr;
    if (xfer) begin
      if (bus.req_last[sel]) begin
        state_nx = IDLE;
        rr_nx    = (int'(sel) == NREQ - 1) ? '0 : sel + SW'(1);
      end else begin
        state_nx = LOCKED;
        grant_nx = sel;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_v     <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
      msg_cnt   <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      rr_ptr <= rr_nx;
      if (out_valid && bus.beat_ready && out_last) msg_cnt <= msg_cnt + 16'd1;
      // Loading while draining replaces the entry with no bubble.
      if (xfer) begin
        out_valid <= 1'b1;
        out_v     <= req_data[sel];
        out_last  <= bus.req_last[sel];
        out_src   <= sel;
      end else if (bus.beat_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.beat_valid = out_valid;
  assign bus.beat_v     = out_v;
  assign bus.beat_last  = out_last;
  assign bus.beat_src   = out_src;
  assign bus.msg_count  = msg_cnt;
endmodule

// File: tb/tb_vsim_send_arb.sv
// Directed and randomized checks of vsim_send_arb against a message-level model.
module tb_vsim_send_arb;
  localparam int W = 32;
  localparam int N = 4;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  vsim_send_arb_if #(.width(W), .NREQ(N)) bus ();
  vsim_send_arb #(.width(W), .NREQ(N)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  int n_chk = 0, n_pass = 0;

  // Bench-side requester state
  logic [31:0] dat [N];
  bit          lst [N];
  bit          vld [N];
  bit          br;
  int          rem [N];

  // Reference model
  bit          m_ov, m_last;
  logic [31:0] m_v;
  int          m_src, owner, nxt, acc_id;
  logic [15:0] m_cnt;
  int          log_s[$];
  logic [31:0] log_d[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]      = vld[i];
      bus.req_v[i*W +: W]   = dat[i];
      bus.req_last[i]       = lst[i];
    end
    bus.beat_ready = br;
  endtask

  task automatic new_beat(input int i);
    dat[i] = $urandom;
    lst[i] = ($urandom_range(0, 2) == 0);
  endtask

  // One clock: compare against model, advance model across the edge.
  task automatic cyc(input bit quiet);
    int w;
    bit can;
    logic [N-1:0] exp_r;
    #1;
    w = -1;
    exp_r = '0;
    can = !m_ov || br;
    if (!nRST) begin
      if (owner < 0) begin
        for (int k = 0; k < N; k++)
          if (w < 0 && vld[(nxt + k) % N]) w = (nxt + k) % N;
      end else w = owner;
      if (w >= 0) exp_r[w] = can;
    end
    if (!quiet) begin
      chk("req_ready",  32'(bus.req_ready),  32'(exp_r));
      chk("beat_valid", 32'(bus.beat_valid), 32'(m_ov));
      chk("beat_v",     bus.beat_v,          m_v);
      chk("beat_last",  32'(bus.beat_last),  32'(m_last));
      chk("beat_src",   32'(bus.beat_src),   m_src);
      chk("msg_count",  32'(bus.msg_count),  32'(m_cnt));
    end
    if (bus.beat_valid && bus.beat_ready) begin
      log_s.push_back(int'(bus.beat_src));
      log_d.push_back(bus.beat_v);
    end
    acc_id = -1;
    if (nRST) begin
      m_ov = 0; m_last = 0; m_v = 0; m_src = 0; owner = -1; nxt = 0; m_cnt = 0;
    end else begin
      if (m_ov && br && m_last) m_cnt++;
      if (w >= 0 && can && vld[w]) begin
        acc_id = w;
        m_ov = 1; m_v = dat[w]; m_last = lst[w]; m_src = w;
        if (lst[w]) begin owner = -1; nxt = (w + 1) % N; end
        else owner = w;
      end else if (br) m_ov = 0;
    end
    @(negedge CLK);
  endtask

  task automatic reset_dut(input bit first);
    nRST = 1'b1;
    for (int i = 0; i < N; i++) vld[i] = 1;
    drive();
    cyc(first);
    cyc(0);
    nRST = 1'b0;
    for (int i = 0; i < N; i++) vld[i] = 0;
    drive();
  endtask

  task automatic set_vld(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) vld[i] = m[i];
  endtask

  initial begin
    owner = -1; nxt = 0; m_cnt = 0; m_ov = 0; m_v = 0; m_last = 0; m_src = 0;
    for (int i = 0; i < N; i++) begin dat[i] = 0; lst[i] = 0; vld[i] = 0; end
    br = 1;
    nRST = 1'b1;
    drive();
    @(negedge CLK);
    reset_dut(1);

    // Single-beat message
    set_vld(4'b0001); dat[0] = 32'hA5; lst[0] = 1; br = 1; drive();
    cyc(0);
    set_vld(4'b0000); drive();
    chk("single_valid", 32'(bus.beat_valid), 1);
    chk("single_v",     bus.beat_v,          32'hA5);
    chk("single_last",  32'(bus.beat_last),  1);
    chk("single_src",   32'(bus.beat_src),   0);
    cyc(0);
    chk("single_cnt", 32'(bus.msg_count), 1);
    set_vld(4'b0011); dat[1] = 32'h11; lst[1] = 1; drive();
    #1 chk("single_rr", 32'(bus.req_ready), 32'h2);
    cyc(0);
    set_vld(4'b0000); drive();
    cyc(0); cyc(0);

    // Contention: four 2-beat messages
    reset_dut(0);
    br = 1;
    for (int i = 0; i < N; i++) rem[i] = 2;
    log_s.delete(); log_d.delete();
    for (int t = 0; t < 40 && log_s.size() < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        vld[i] = rem[i] > 0; dat[i] = 32'(i * 16 + rem[i]); lst[i] = rem[i] == 1;
      end
      drive();
      cyc(0);
      if (acc_id >= 0) rem[acc_id]--;
    end
    chk("contention_beats", log_s.size(), 8);
    for (int j = 0; j < 8 && j < log_s.size(); j++) chk("contention_src", log_s[j], j / 2);
    chk("contention_cnt", 32'(bus.msg_count), 4);

    // Lock held while grantee stalls
    reset_dut(0);
    br = 1;
    set_vld(4'b0010); dat[1] = 32'h11; lst[1] = 0; drive();
    cyc(0);
    set_vld(4'b0100); dat[2] = 32'h22; lst[2] = 1;
    for (int t = 0; t < 3; t++) begin
      drive();
      #1 chk("lock_r2", 32'(bus.req_ready[2]), 0);
      cyc(0);
    end
    set_vld(4'b0110); dat[1] = 32'h12; lst[1] = 1; drive();
    #1 chk("lock_resume", 32'(bus.req_ready), 32'h2);
    cyc(0);
    set_vld(4'b0100); drive();
    #1 chk("lock_next", 32'(bus.req_ready), 32'h4);
    cyc(0);
    set_vld(4'b0000); drive();
    cyc(0); cyc(0);

    // Backpressure
    reset_dut(0);
    set_vld(4'b0001); dat[0] = 100; lst[0] = 1; br = 0; drive();
    cyc(0);
    dat[0] = 101;
    for (int t = 0; t < 5; t++) begin
      drive();
      #1 chk("bp_ready", 32'(bus.req_ready), 0);
      chk("bp_hold", bus.beat_v, 100);
      cyc(0);
    end
    br = 1;
    log_s.delete(); log_d.delete();
    for (int t = 0; t < 6; t++) begin
      drive();
      cyc(0);
      if (acc_id == 0) dat[0]++;
    end
    set_vld(4'b0000); drive();
    cyc(0); cyc(0);
    chk("bp_count", log_d.size(), 7);
    for (int j = 0; j < log_d.size(); j++) chk("bp_data", log_d[j], 32'(100 + j));

    // Reset in the middle of a 4-beat message
    reset_dut(0);
    br = 1; rem[0] = 4;
    for (int t = 0; t < 10 && rem[0] > 2; t++) begin
      vld[0] = 1; dat[0] = 32'h40 + 32'(rem[0]); lst[0] = rem[0] == 1;
      drive();
      cyc(0);
      if (acc_id == 0) rem[0]--;
    end
    chk("rst_mid_progress", rem[0], 2);
    nRST = 1'b1; set_vld(4'b1111); drive();
    cyc(0);
    #1 chk("rst_mid_valid", 32'(bus.beat_valid), 0);
    chk("rst_mid_ready", 32'(bus.req_ready), 0);
    nRST = 1'b0; drive();
    #1 chk("rst_mid_grant", 32'(bus.req_ready), 32'h1);
    cyc(0);

    // Randomized traffic with occasional reset
    reset_dut(0);
    for (int i = 0; i < N; i++) new_beat(i);
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) vld[i] = ($urandom_range(0, 3) != 0);
      br   = ($urandom_range(0, 3) != 0);
      nRST = ($urandom_range(0, 299) == 0);
      drive();
      cyc(0);
      if (acc_id >= 0) new_beat(acc_id);
    end
    nRST = 1'b0;

    // msg_count wrap after 65536 single-beat messages
    reset_dut(0);
    set_vld(4'b0001); dat[0] = 32'h5; lst[0] = 1; br = 1; drive();
    for (int t = 0; t < 65536; t++) cyc(1);
    set_vld(4'b0000); drive();
    cyc(0);
    chk("wrap_cnt", 32'(bus.msg_count), 0);
    chk("wrap_model", 32'(bus.msg_count), 32'(m_cnt));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vsim_send_arb.md
VSIM_SEND_ARB -- requirements
Module: vsim_send_arb

Interface
REQ-001 SHALL have parameter: width, 32, data bits per beat.
REQ-002 SHALL have parameter: NREQ, 4, number of requester ports (2..8).
REQ-003 SHALL have port: CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 SHALL have port: nRST  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port: req_valid  input  NREQ  requester i presents a beat.
REQ-006 SHALL have port: req_v  input  NREQ*width  beat data; requester i at bits [i*width +: width].
REQ-007 SHALL have port: req_last  input  NREQ  beat i is the last beat of its message.
REQ-008 SHALL have port: req_ready  output  NREQ  beat from requester i accepted this cycle when req_valid[i]&req_ready[i].
REQ-009 SHALL have port: beat_valid  output  1  output beat present.
REQ-010 SHALL have port: beat_ready  input  1  downstream send port accepts beat.
REQ-011 SHALL have port: beat_v  output  width  output beat data.
REQ-012 SHALL have port: beat_last  output  1  output beat ends message.
REQ-013 SHALL have port: beat_src  output  $clog2(NREQ)  index of requester owning output beat.
REQ-014 SHALL have port: msg_count  output  16  count of messages completed at output.

Function
REQ-015 SHALL merge NREQ beat streams onto one output at message granularity; beats of different messages never interleave.
REQ-016 SHALL hold a one-entry output register (out_valid, data, last, src); beat_valid/v/last/src driven directly from it.
REQ-017 SHALL define can_load = !out_valid | beat_ready; a requester beat transfers only when can_load.
REQ-018 SHALL implement states IDLE (no message owned) and LOCKED (grant register owns the output).
REQ-019 IDLE: winner = first i with req_valid[i], searching from rr_ptr upward modulo NREQ; req_ready[winner]=can_load, all others 0.
REQ-020 IDLE and winner beat transfers with last=0: SHALL go LOCKED, grant<=winner.
REQ-021 IDLE and winner beat transfers with last=1 (single-beat message): SHALL stay IDLE, rr_ptr<=(winner+1) mod NREQ.
REQ-022 LOCKED: req_ready[grant]=can_load, all others 0; other requesters' valid ignored.
REQ-023 LOCKED and grant beat transfers with last=1: SHALL go IDLE, rr_ptr<=(grant+1) mod NREQ.
REQ-024 req_ready SHALL be combinational from state, rr_ptr, req_valid, out_valid, beat_ready; no requester ever sees ready when can_load=0.
REQ-025 Latency: accepted beat SHALL appear on beat_valid the next cycle; sustained throughput one beat per cycle when beat_ready held 1.
REQ-026 Output register: on transfer load beat; else if beat_ready clear out_valid; else hold all fields.
REQ-027 Simultaneous drain and load SHALL replace the register contents with no bubble.
REQ-028 msg_count SHALL increment by 1 on each cycle beat_valid&beat_ready&beat_last; wraps 0xFFFF->0x0000.
REQ-029 No requester valid in IDLE: no transfer, state and rr_ptr unchanged.
REQ-030 Granted requester dropping req_valid mid-message: SHALL stay LOCKED on it (no timeout).
REQ-031 beat_v/beat_last/beat_src SHALL not change while beat_valid=1 and beat_ready=0.

Reset
REQ-032 With nRST=1 at posedge CLK: out_valid=0, state=IDLE, grant=0, rr_ptr=0, msg_count=0; beat_v/beat_last/beat_src=0.
REQ-033 During reset req_ready SHALL be 0 for all requesters and no beat accepted.
REQ-034 Reset mid-message SHALL discard the output register and lock; first post-reset grant uses rr_ptr=0.

Verification
REQ-035 Single beat: req_valid=0001, req_v[0]=0xA5, last=1, beat_ready=1 -> next cycle beat_valid=1, v=0xA5, last=1, src=0; msg_count=1 one cycle later; rr_ptr=1.
REQ-036 Contention: all four valid, 2-beat messages each, beat_ready=1 -> output order src 0,0,1,1,2,2,3,3, no interleave, msg_count=4.
REQ-037 Lock: req 1 sends beat (last=0) then drops valid 3 cycles while req 2 valid -> req_ready[2]=0 throughout; req 1 resumes, completes, then req 2 granted.
REQ-038 Backpressure: beat_ready=0 for 5 cycles with out_valid=1 -> req_ready all 0, beat_v stable; beat_ready=1 -> back-to-back beats, no loss or duplicate.
REQ-039 Wrap: preload msg_count path with 65536 single-beat messages -> msg_count returns to 0x0000.
REQ-040 Reset mid-message: nRST=1 after 2 of 4 beats -> beat_valid=0, req_ready=0; after release, req 0 granted first if valid.
